// File: rtl/stopwatch_pkg.sv
// Shared BCD types and helpers for the stopwatch count path.
package stopwatch_pkg;

  localparam int BCD_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [BCD_DIGITS-1:0] bcd_word_t;

  // True when every nibble of the word is a legal decimal digit.
  function automatic logic bcd_valid(input bcd_word_t word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (word[i] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the up/down chain: steps by one with carry/borrow out.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       step_in,
  output bcd_digit_t next_digit,
  output logic       step_out
);

  always_comb begin
    next_digit = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (up) begin
        if (digit >= 4'd9) begin
          next_digit = 4'd0;
          step_out   = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next_digit = 4'd9;
          step_out   = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Four-digit saturating BCD up/down counter with prescaler and validated load.
module bcd_updown_counter #(
  parameter int          TICK_DIV = 1000,
  parameter logic [15:0] MAX_BCD  = 16'h4930,
  parameter logic [15:0] MIN_BCD  = 16'h1020
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        COUNT,
  input  logic        UpDown,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VAL,
  output logic [15:0] Q,
  output logic        tick,
  output logic        at_max,
  output logic        at_min,
  output logic        load_err
);
  import stopwatch_pkg::*;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0]         pcnt;
  bcd_word_t           q_word;
  bcd_word_t           stepped;
  logic [BCD_DIGITS:0] chain;
  logic                load_ok;
  logic                step_ok;

  assign q_word   = Q;
  assign chain[0] = 1'b1;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit      (q_word[i]),
      .up         (UpDown),
      .step_in    (chain[i]),
      .next_digit (stepped[i]),
      .step_out   (chain[i+1])
    );
  end

  // Gated by RST so tick drops the instant reset asserts, even with TICK_DIV = 1.
  assign tick    = RST & COUNT & (pcnt == TICK_LAST);
  assign at_max  = (Q == MAX_BCD);
  assign at_min  = (Q == MIN_BCD);
  assign load_ok = bcd_valid(LOAD_VAL) && (LOAD_VAL >= MIN_BCD) && (LOAD_VAL <= MAX_BCD);
  assign step_ok = (UpDown ? !at_max : !at_min) && !chain[BCD_DIGITS];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pcnt <= 16'd0;
    end else if (COUNT) begin
      pcnt <= (pcnt == TICK_LAST) ? 16'd0 : pcnt + 16'd1;
    end
  end

  // A load request always swallows a coincident tick, accepted or not.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Q        <= MIN_BCD;
      load_err <= 1'b0;
    end else begin
      load_err <= LOAD & ~load_ok;
      if (LOAD) begin
        if (load_ok) Q <= LOAD_VAL;
      end else if (tick && step_ok) begin
        Q <= stepped;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed vector bench for bcd_updown_counter (TICK_DIV 1 and 4 instances).
module tb_bcd_updown_counter;

  typedef struct {
    logic        load;
    logic [15:0] load_val;
    logic        count;
    logic        up_down;
    logic [15:0] q;
    logic        tick;
    logic        at_max;
    logic        at_min;
    logic        load_err;
  } vector_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        COUNT;
  logic        UpDown;
  logic        LOAD;
  logic [15:0] LOAD_VAL;

  logic [15:0] q1, q4;
  logic        tick1, tick4, at_max1, at_max4, at_min1, at_min4, load_err1, load_err4;

  int check_count = 0;
  int error_count = 0;

  vector_t vecs[21];

  always #5 CLK = ~CLK;

  bcd_updown_counter #(.TICK_DIV(1), .MAX_BCD(16'h4930), .MIN_BCD(16'h1020)) dut1 (
    .CLK(CLK), .RST(RST), .COUNT(COUNT), .UpDown(UpDown), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .Q(q1), .tick(tick1), .at_max(at_max1), .at_min(at_min1), .load_err(load_err1)
  );

  bcd_updown_counter #(.TICK_DIV(4), .MAX_BCD(16'h4930), .MIN_BCD(16'h1020)) dut4 (
    .CLK(CLK), .RST(RST), .COUNT(COUNT), .UpDown(UpDown), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .Q(q4), .tick(tick4), .at_max(at_max4), .at_min(at_min4), .load_err(load_err4)
  );

  function automatic vector_t mk(input logic load, input logic [15:0] val, input logic count,
                                 input logic up, input logic [15:0] q, input logic tk,
                                 input logic mx, input logic mn, input logic err);
    vector_t v;
    v.load = load; v.load_val = val; v.count = count; v.up_down = up;
    v.q = q; v.tick = tk; v.at_max = mx; v.at_min = mn; v.load_err = err;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    LOAD     = v.load;
    LOAD_VAL = v.load_val;
    COUNT    = v.count;
    UpDown   = v.up_down;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input int idx, input vector_t v);
    check16($sformatf("vec%0d q", idx), q1, v.q);
    check1($sformatf("vec%0d tick", idx), tick1, v.tick);
    check1($sformatf("vec%0d at_max", idx), at_max1, v.at_max);
    check1($sformatf("vec%0d at_min", idx), at_min1, v.at_min);
    check1($sformatf("vec%0d load_err", idx), load_err1, v.load_err);
  endtask

  initial begin
    int ticks;
    int pat[9];

    vecs[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1020, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 16'h1999, 1'b0, 1'b0, 16'h1999, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2001, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 16'h1021, 1'b0, 1'b0, 16'h1021, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1020, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1020, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1020, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 16'h4929, 1'b0, 1'b1, 16'h4929, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4930, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4930, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4930, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4930, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4930, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 16'h12A0, 1'b0, 1'b1, 16'h4930, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h4930, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 16'h5000, 1'b0, 1'b1, 16'h4930, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h4930, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 16'h0999, 1'b0, 1'b1, 16'h4930, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[19] = mk(1'b1, 16'h3000, 1'b1, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(1'b1, 16'h2345, 1'b1, 1'b0, 16'h2345, 1'b1, 1'b0, 1'b0, 1'b0);

    RST = 1'b0; COUNT = 1'b0; UpDown = 1'b0; LOAD = 1'b0; LOAD_VAL = 16'h0000;
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Asynchronous reset while counting from 2345: must act without a clock edge.
    RST = 1'b0;
    #1;
    check16("async_reset q", q1, 16'h1020);
    check1("async_reset at_min", at_min1, 1'b1);
    check1("async_reset at_max", at_max1, 1'b0);
    check1("async_reset tick", tick1, 1'b0);
    check1("async_reset load_err", load_err1, 1'b0);
    LOAD = 1'b0; COUNT = 1'b0; UpDown = 1'b1;
    @(negedge CLK);
    RST = 1'b1;

    // Prescaler pause on the divide-by-4 instance: 2 high, 5 low, 2 high.
    pat = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      COUNT = pat[i][0];
      #1;
      if (tick4) ticks++;
      @(negedge CLK);
      if (i == 6) begin
        check16("pause q_held", q4, 16'h1020);
        check16("pause no_early_tick", 16'(ticks), 16'd0);
      end
    end
    COUNT = 1'b0;
    check16("pause tick_count", 16'(ticks), 16'd1);
    check16("pause q_step", q4, 16'h1021);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
